// File: rtl/nabp_processing_data_path_pkg.sv
// Shared definitions for the NABP processing read-side data path:
// geometry, angle thresholds, FSM encoding and the per-run configuration.
package nabp_processing_data_path_pkg;

  localparam int kNoOfPartitions     = 4;
  localparam int kPartitionSize      = 8;
  localparam int kImageSize          = 32;
  localparam int kProjectionLineSize = 64;
  localparam int kAngleLength        = 9;
  localparam int kTrigLength         = 16;
  localparam int kTrigFrac           = 12;
  localparam int kFilteredDataLength = 16;

  localparam int kSLength       = $clog2(kProjectionLineSize);
  localparam int kLineItrLength = $clog2(kPartitionSize);
  localparam int kCoordLength   = $clog2(kImageSize);
  localparam int kPeIdxLength   = $clog2(kNoOfPartitions);

  // Angle codes are whole degrees over 0..179.
  localparam logic [kAngleLength-1:0] kAngle45  = kAngleLength'(45);
  localparam logic [kAngleLength-1:0] kAngle90  = kAngleLength'(90);
  localparam logic [kAngleLength-1:0] kAngle135 = kAngleLength'(135);

  typedef enum logic {kScanX = 1'b0, kScanY = 1'b1} scan_mode_e;

  localparam logic [2:0] kStIdle  = 3'd0;
  localparam logic [2:0] kStRead  = 3'd1;
  localparam logic [2:0] kStWait1 = 3'd2;
  localparam logic [2:0] kStWait2 = 3'd3;
  localparam logic [2:0] kStEmit  = 3'd4;
  localparam logic [2:0] kStDone  = 3'd5;

  // Everything a run needs from the tt_* inputs, latched once at start.
  typedef struct packed {
    scan_mode_e                    mode;
    logic                          desc;
    logic signed [kTrigLength-1:0] trig_sin;
    logic signed [kTrigLength-1:0] trig_cos;
    logic [kLineItrLength-1:0]     line_itr;
  } run_cfg_t;

  function automatic run_cfg_t decode_cfg(
    input logic [kAngleLength-1:0]   angle,
    input logic signed [kTrigLength-1:0] sin_v,
    input logic signed [kTrigLength-1:0] cos_v,
    input logic [kLineItrLength-1:0] itr
  );
    run_cfg_t c;
    c.mode     = (angle < kAngle45 || angle >= kAngle135) ? kScanX : kScanY;
    c.desc     = (angle >= kAngle90);
    c.trig_sin = sin_v;
    c.trig_cos = cos_v;
    c.line_itr = itr;
    return c;
  endfunction

endpackage

// File: rtl/nabp_processing_data_path_projection_calc.sv
// Projection of pixel (x, y) onto the filtered line: registered s index
// plus out-of-range flag, one cycle latency. s holds its last in-range
// value so no spurious RAM address is issued for an off-line sample.
module nabp_projection_calc
  import nabp_processing_data_path_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en_i,
  input  logic [kCoordLength-1:0]       x_i,
  input  logic [kCoordLength-1:0]       y_i,
  input  logic signed [kTrigLength-1:0] sin_i,
  input  logic signed [kTrigLength-1:0] cos_i,
  output logic [kSLength-1:0]           s_o,
  output logic                          oor_o
);

  int xc, yc, s_fix, s_rnd;
  logic oor;
  logic [kSLength-1:0] s_q;
  logic                oor_q;

  // Centre the pixel, rotate into s, round half up back to an integer index.
  always_comb begin
    xc    = int'(x_i) - kImageSize / 2;
    yc    = int'(y_i) - kImageSize / 2;
    s_fix = -(xc * int'(sin_i)) + yc * int'(cos_i)
            + ((kProjectionLineSize / 2) << kTrigFrac);
    s_rnd = (s_fix + (1 << (kTrigFrac - 1))) >>> kTrigFrac;
    oor   = (s_rnd < 0) || (s_rnd >= kProjectionLineSize);
  end

  // Address register: only moves for in-range samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_q   <= '0;
      oor_q <= 1'b0;
    end else if (en_i) begin
      oor_q <= oor;
      if (!oor) s_q <= kSLength'(s_rnd);
    end
  end

  assign s_o   = s_q;
  assign oor_o = oor_q;

endmodule

// File: rtl/nabp_processing_data_path.sv
// Read-side initiator for the processing swappables: walks one scan line
// per PE, issues filtered-RAM reads, gathers returned samples into pe_taps
// and strobes pe_en once per scan step (N+3 cycles per step).
module nabp_processing_data_path
  import nabp_processing_data_path_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [kAngleLength-1:0]                      tt_angle,
  input  logic signed [kTrigLength-1:0]                tt_sin,
  input  logic signed [kTrigLength-1:0]                tt_cos,
  input  logic [kLineItrLength-1:0]                    tt_line_itr,
  input  logic                                         tt_kick,
  output logic                                         tt_done,
  output logic [kSLength-1:0]                          pv_s_val,
  input  logic [kFilteredDataLength-1:0]               pv_val,
  output logic                                         pe_en,
  output logic [kFilteredDataLength*kNoOfPartitions-1:0] pe_taps
);

  localparam logic [kPeIdxLength-1:0] kLastPe   = kPeIdxLength'(kNoOfPartitions - 1);
  localparam logic [kCoordLength-1:0] kLastStep = kCoordLength'(kImageSize - 1);

  logic [2:0]              state_q, state_d;
  run_cfg_t                cfg_q, cfg_d;
  logic [kCoordLength-1:0] step_q, step_d;
  logic [kPeIdxLength-1:0] pe_q, pe_d;
  logic                    kick_q;

  logic [kCoordLength-1:0] scan, line_i, calc_x, calc_y;
  logic                    rd_issue, calc_oor;

  // Read pipe: [1] = address registered, [2] = pv_val valid this cycle.
  logic [2:1]              vld_pipe_q;
  logic [kPeIdxLength-1:0] idx1_q, idx2_q;
  logic                    oor2_q;

  logic [kNoOfPartitions-1:0][kFilteredDataLength-1:0] shadow_q, taps_q, taps_nxt;
  logic [kFilteredDataLength-1:0] cap_val;

  // Pixel coordinates for the current (scan step, PE) pair.
  always_comb begin
    scan     = cfg_q.desc ? (kLastStep - step_q) : step_q;
    line_i   = kCoordLength'(cfg_q.line_itr)
               + kCoordLength'(pe_q) * kCoordLength'(kPartitionSize);
    calc_x   = (cfg_q.mode == kScanX) ? scan : line_i;
    calc_y   = (cfg_q.mode == kScanX) ? line_i : scan;
    rd_issue = (state_q == kStRead);
  end

  nabp_projection_calc u_calc (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (rd_issue),
    .x_i     (calc_x),
    .y_i     (calc_y),
    .sin_i   (cfg_q.trig_sin),
    .cos_i   (cfg_q.trig_cos),
    .s_o     (pv_s_val),
    .oor_o   (calc_oor)
  );

  // Sequencer: start on kick falling edge, N reads, two wait slots, emit.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    step_d  = step_q;
    pe_d    = pe_q;
    case (state_q)
      kStIdle: if (kick_q && !tt_kick) begin
        cfg_d   = decode_cfg(tt_angle, tt_sin, tt_cos, tt_line_itr);
        step_d  = '0;
        pe_d    = '0;
        state_d = kStRead;
      end
      kStRead: begin
        pe_d = (pe_q == kLastPe) ? '0 : pe_q + 1'b1;
        if (pe_q == kLastPe) state_d = kStWait1;
      end
      kStWait1: state_d = kStWait2;
      kStWait2: state_d = kStEmit;
      kStEmit: begin
        if (step_q == kLastStep) state_d = kStDone;
        else begin
          step_d  = step_q + 1'b1;
          pe_d    = '0;
          state_d = kStRead;
        end
      end
      default: state_d = kStIdle;
    endcase
  end

  // FSM and run-state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= kStIdle;
      cfg_q   <= '0;
      step_q  <= '0;
      pe_q    <= '0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      step_q  <= step_d;
      pe_q    <= pe_d;
      kick_q  <= tt_kick;
    end
  end

  // Delay PE index and range flag so they line up with pv_val.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      oor2_q     <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], rd_issue};
      idx1_q     <= pe_q;
      idx2_q     <= idx1_q;
      oor2_q     <= calc_oor;
    end
  end

  // Returned sample, forced to zero for off-line pixels.
  always_comb begin
    cap_val           = oor2_q ? '0 : pv_val;
    taps_nxt          = shadow_q;
    taps_nxt[idx2_q]  = cap_val;
  end

  // Collect taps in a shadow, publish all at once entering EMIT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '0;
      taps_q   <= '0;
    end else if (vld_pipe_q[2]) begin
      shadow_q[idx2_q] <= cap_val;
      if (idx2_q == kLastPe) taps_q <= taps_nxt;
    end
  end

  assign pe_en   = (state_q == kStEmit);
  assign tt_done = (state_q == kStDone);
  assign pe_taps = taps_q;

endmodule

// File: tb/tb_nabp_processing_data_path.sv
// Randomised scoreboard bench: expected taps per scan step are queued when
// a run is kicked; a negedge monitor pops and compares on every pe_en.
module tb_nabp_processing_data_path;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  tt_angle = '0;
  logic signed [15:0] tt_sin = '0, tt_cos = '0;
  logic [2:0]  tt_line_itr = '0;
  logic        tt_kick = 1'b0;
  logic        tt_done;
  logic [5:0]  pv_s_val;
  logic [15:0] pv_val = '0;
  logic        pe_en;
  logic [63:0] pe_taps;

  nabp_processing_data_path dut (
    .clk(clk), .reset_n(reset_n), .tt_angle(tt_angle), .tt_sin(tt_sin),
    .tt_cos(tt_cos), .tt_line_itr(tt_line_itr), .tt_kick(tt_kick),
    .tt_done(tt_done), .pv_s_val(pv_s_val), .pv_val(pv_val),
    .pe_en(pe_en), .pe_taps(pe_taps)
  );

  always #5 clk = ~clk;

  // Filtered RAM stand-in: data = address, one cycle latency.
  always @(posedge clk) pv_val <= {10'd0, pv_s_val};

  int n_chk = 0, n_fail = 0, done_cnt = 0, cyc = 0, last_en = -1;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: pixel geometry and rounded projection, real arithmetic.
  function automatic logic [63:0] model_taps(input int angle, input int sn, input int cs,
                                              input int itr, input int k);
    logic [63:0] e;
    int scan, x, y, s;
    real num;
    e = '0;
    scan = (angle >= 90) ? 31 - k : k;
    for (int i = 0; i < 4; i++) begin
      if (angle < 45 || angle >= 135) begin x = scan; y = itr + 8 * i; end
      else begin x = itr + 8 * i; y = scan; end
      num = -(real'(x) - 16.0) * real'(sn) + (real'(y) - 16.0) * real'(cs);
      s = int'($floor(num / 4096.0 + 32.0 + 0.5));
      e[16*i +: 16] = (s < 0 || s >= 64) ? 16'd0 : 16'(s);
    end
    return e;
  endfunction

  // Monitor: scoreboard pop on pe_en, spacing check, done counting.
  always @(negedge clk) begin
    if (!reset_n) last_en = -1;
    else begin
      if (pe_en) begin
        if (exp_q.size() == 0) check("unexpected_pe_en", 64'd1, 64'd0);
        else check("pe_taps", pe_taps, exp_q.pop_front());
        if (last_en >= 0) check("pe_en_spacing", 64'(cyc - last_en), 64'd7);
        last_en = cyc;
      end
      if (tt_done) begin
        done_cnt++;
        last_en = -1;
      end
    end
  end

  task automatic kick();
    @(posedge clk); #1 tt_kick = 1'b1;
    @(posedge clk); #1 tt_kick = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (tt_done) seen = 1'b1;
    end
  endtask

  task automatic run(input int angle, input int sn, input int cs, input int itr,
                     input bit disturb);
    int d0;
    bit seen;
    d0 = done_cnt;
    @(posedge clk); #1;
    tt_angle = 9'(angle); tt_sin = 16'(sn); tt_cos = 16'(cs); tt_line_itr = 3'(itr);
    for (int k = 0; k < 32; k++) exp_q.push_back(model_taps(angle, sn, cs, itr, k));
    kick();
    if (disturb) begin
      repeat (20) @(posedge clk);
      #1 tt_sin = 16'($urandom); tt_angle = 9'($urandom_range(0, 179));
      kick();
    end
    wait_done(seen);
    check("done_seen", 64'(seen), 64'd1);
    repeat (20) @(posedge clk);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_pe_taps", pe_taps, 64'd0);
    check("rst_pe_en", 64'(pe_en), 64'd0);
    check("rst_tt_done", 64'(tt_done), 64'd0);
    check("rst_pv_s_val", 64'(pv_s_val), 64'd0);

    run(0, 0, 4096, 3, 1'b0);
    run(90, 4096, 0, 0, 1'b0);
    run(45, 16'h0B50, 16'h0B50, $urandom_range(0, 7), 1'b0);
    run(0, 0, 16'h4000, 7, 1'b0);
    run(135, -2896, 2896, 5, 1'b0);
    run($urandom_range(0, 179), 1000, -3000, 2, 1'b1);
    for (int r = 0; r < 6; r++)
      run($urandom_range(0, 179), $urandom_range(0, 8192) - 4096,
          $urandom_range(0, 8192) - 4096, $urandom_range(0, 7), 1'b0);

    // Abort mid-run with a one-cycle reset.
    @(posedge clk); #1;
    tt_angle = 9'd10; tt_sin = 16'd700; tt_cos = 16'd4000; tt_line_itr = 3'd1;
    for (int k = 0; k < 32; k++) exp_q.push_back(model_taps(10, 700, 4000, 1, k));
    kick();
    repeat (40) @(posedge clk);
    d0 = done_cnt;
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_q.delete();
    check("abort_pe_taps", pe_taps, 64'd0);
    check("abort_pe_en", 64'(pe_en), 64'd0);
    check("abort_tt_done", 64'(tt_done), 64'd0);
    check("abort_pv_s_val", 64'(pv_s_val), 64'd0);
    repeat (300) @(posedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run(100, 3500, -2000, 6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
